// File: rtl/wav_stream_ctrl.sv
// WAV recorder front end: emits a 44-byte PCM header, then converts and streams
// 16-bit stereo frames to a ready/valid byte sink until NUM_FRAMES are written.
module wav_stream_ctrl #(
    parameter logic [31:0] SAMPLE_RATE_HZ = 32'd44100,
    parameter logic [31:0] NUM_FRAMES     = 32'd44100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [23:0] in_L,
    input  logic [23:0] in_R,
    output logic        in_ready,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] frame_cnt
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_WAIT_IN,
        S_STREAM,
        S_DONE
    } state_t;

    localparam logic [31:0] DATA_BYTES = NUM_FRAMES * 32'd4;
    localparam logic [31:0] RIFF_SIZE  = DATA_BYTES + 32'd36;
    localparam logic [31:0] BYTE_RATE  = SAMPLE_RATE_HZ * 32'd4;
    localparam logic [5:0]  LAST_HDR   = 6'd43;

    // Header byte 0 lives in the LSBs; reversed string literals put the first character lowest.
    localparam logic [351:0] HEADER = {
        DATA_BYTES, "atad", 16'd16, 16'd4, BYTE_RATE, SAMPLE_RATE_HZ,
        16'd2, 16'd1, 32'd16, " tmf", "EVAW", RIFF_SIZE, "FFIR"
    };

    state_t      state_q, state_d;
    logic [5:0]  idx_q, idx_d, idx_inc;
    logic [15:0] l_q, l_d, r_q, r_d, conv_l, conv_r;
    logic [31:0] frame_cnt_q, frame_cnt_d, frame_inc;
    logic [7:0]  byte_out_q, byte_out_d;
    logic        byte_valid_q, byte_valid_d;
    logic        in_ready_q, in_ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        accept;

    logic unused_upper;
    assign unused_upper = ^{in_L[23:16], in_R[23:16]};

    function automatic logic [7:0] stream_byte(input logic [1:0] sel,
                                               input logic [15:0] l,
                                               input logic [15:0] r);
        case (sel)
            2'd0:    return l[7:0];
            2'd1:    return l[15:8];
            2'd2:    return r[7:0];
            default: return r[15:8];
        endcase
    endfunction

    // Flipping the MSB is the same as adding 32768 modulo 2^16.
    assign conv_l    = {~in_L[15], in_L[14:0]};
    assign conv_r    = {~in_R[15], in_R[14:0]};
    assign idx_inc   = idx_q + 6'd1;
    assign frame_inc = frame_cnt_q + 32'd1;
    assign accept    = byte_valid_q && byte_ready;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        idx_d       = idx_q;
        l_d         = l_q;
        r_d         = r_q;
        frame_cnt_d = frame_cnt_q;
        byte_out_d  = byte_out_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_HEADER;
                    idx_d       = '0;
                    frame_cnt_d = '0;
                    byte_out_d  = HEADER[7:0];
                end
            end
            S_HEADER: begin
                if (accept) begin
                    if (idx_q == LAST_HDR) begin
                        state_d = (NUM_FRAMES == 32'd0) ? S_DONE : S_WAIT_IN;
                    end else begin
                        idx_d      = idx_inc;
                        byte_out_d = HEADER[{idx_inc, 3'b000} +: 8];
                    end
                end
            end
            S_WAIT_IN: begin
                if (in_valid && in_ready_q) begin
                    state_d    = S_STREAM;
                    idx_d      = '0;
                    l_d        = conv_l;
                    r_d        = conv_r;
                    byte_out_d = conv_l[7:0];
                end
            end
            S_STREAM: begin
                if (accept) begin
                    if (idx_q[1:0] == 2'd3) begin
                        frame_cnt_d = frame_inc;
                        state_d     = (frame_inc == NUM_FRAMES) ? S_DONE : S_WAIT_IN;
                    end else begin
                        idx_d      = idx_inc;
                        byte_out_d = stream_byte(idx_inc[1:0], l_q, r_q);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status flags are decoded from the next state so they register alongside it.
        byte_valid_d = (state_d == S_HEADER) || (state_d == S_STREAM);
        in_ready_d   = (state_d == S_WAIT_IN);
        busy_d       = byte_valid_d || in_ready_d;
        done_d       = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            l_q          <= '0;
            r_q          <= '0;
            frame_cnt_q  <= '0;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            l_q          <= l_d;
            r_q          <= r_d;
            frame_cnt_q  <= frame_cnt_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_wav_stream_ctrl.sv
// Scoreboard bench for wav_stream_ctrl: four instances with different frame counts,
// expected bytes queued at stimulus time and popped as the sink accepts them.
module tb_wav_stream_ctrl;

    localparam logic [3:0][31:0] NF_TAB = {32'd0, 32'd3, 32'd1, 32'd44100};
    localparam logic [31:0]      SR     = 32'd44100;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [23:0] in_L = '0;
    logic [23:0] in_R = '0;
    logic        byte_ready = 1'b1;

    logic        st [4];
    logic        ir [4];
    logic [7:0]  bo [4];
    logic        bv [4];
    logic        by [4];
    logic        dn [4];
    logic [31:0] fc [4];

    int          n_checks = 0;
    int          n_pass = 0;
    int          sel = 0;
    bit          toggle_mode = 1'b0;
    logic [7:0]  exp_q [$];
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_byte = '0;
    logic [7:0]  exp_b;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        wav_stream_ctrl #(
            .SAMPLE_RATE_HZ(SR),
            .NUM_FRAMES    (NF_TAB[g])
        ) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .start     (st[g]),
            .in_valid  (in_valid),
            .in_L      (in_L),
            .in_R      (in_R),
            .in_ready  (ir[g]),
            .byte_out  (bo[g]),
            .byte_valid(bv[g]),
            .byte_ready(byte_ready),
            .busy      (by[g]),
            .done      (dn[g]),
            .frame_cnt (fc[g])
        );
    end

    // Sink side: compare each accepted byte against the scoreboard and check stall holding.
    always @(negedge clk) begin
        if (prev_stall) begin
            n_checks++;
            if (bv[sel] !== 1'b1 || bo[sel] !== prev_byte)
                $display("FAIL stall_hold: byte_out=%h valid=%b, required %h valid=1",
                         bo[sel], bv[sel], prev_byte);
            else n_pass++;
        end
        if (bv[sel] === 1'b1 && byte_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_byte: got %h, no byte expected", bo[sel]);
            end else begin
                exp_b = exp_q.pop_front();
                if (bo[sel] !== exp_b)
                    $display("FAIL byte_seq: got %h, required %h", bo[sel], exp_b);
                else n_pass++;
            end
        end
        prev_stall = (bv[sel] === 1'b1) && !byte_ready;
        prev_byte  = bo[sel];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_mode) byte_ready = ~byte_ready;
    endtask

    task automatic push32(input logic [31:0] v);
        for (int i = 0; i < 4; i++) exp_q.push_back(v[i*8 +: 8]);
    endtask

    task automatic push16(input logic [15:0] v);
        exp_q.push_back(v[7:0]);
        exp_q.push_back(v[15:8]);
    endtask

    task automatic push_str(input logic [31:0] s);
        for (int i = 3; i >= 0; i--) exp_q.push_back(s[i*8 +: 8]);
    endtask

    task automatic push_header(input logic [31:0] nf, input logic [31:0] sr);
        push_str("RIFF");
        push32(nf * 32'd4 + 32'd36);
        push_str("WAVE");
        push_str("fmt ");
        push32(32'd16);
        push16(16'd1);
        push16(16'd2);
        push32(sr);
        push32(sr * 32'd4);
        push16(16'd4);
        push16(16'd16);
        push_str("data");
        push32(nf * 32'd4);
    endtask

    task automatic push_frame(input logic [23:0] l, input logic [23:0] r);
        logic [15:0] l16, r16;
        l16 = l[15:0] + 16'h8000;
        r16 = r[15:0] + 16'h8000;
        push16(l16);
        push16(r16);
    endtask

    task automatic pulse_start();
        st[sel] = 1'b1;
        tick();
        st[sel] = 1'b0;
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL %s_timeout: %0d bytes still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end else n_pass++;
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
        int n = 0;
        push_frame(l, r);
        in_L = l;
        in_R = r;
        in_valid = 1'b1;
        while (ir[sel] !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        n_checks++;
        if (ir[sel] !== 1'b1) $display("FAIL in_ready_timeout: in_ready=%b, required 1", ir[sel]);
        else n_pass++;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({bo[i], bv[i], ir[i], by[i], dn[i], fc[i]} !== '0)
                $display("FAIL reset_outputs[%0d]: byte_out=%h valid=%b ready=%b busy=%b done=%b cnt=%0d, required all 0",
                         i, bo[i], bv[i], ir[i], by[i], dn[i], fc[i]);
            else n_pass++;
        end
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_default_header();
        sel = 0;
        push_header(NF_TAB[0], SR);
        pulse_start();
        drain(200, "hdr_default");
        n_checks++;
        if (ir[0] !== 1'b1 || bv[0] !== 1'b0 || by[0] !== 1'b1)
            $display("FAIL hdr_then_wait: in_ready=%b valid=%b busy=%b, required 1 0 1", ir[0], bv[0], by[0]);
        else n_pass++;
    endtask

    task automatic test_single_frame();
        sel = 1;
        push_header(NF_TAB[1], SR);
        pulse_start();
        repeat (5) tick();
        pulse_start();
        drain(200, "hdr_one");
        send_frame(24'h000000, 24'h007FFF);
        drain(50, "frame_one");
        n_checks++;
        if (dn[1] !== 1'b1 || fc[1] !== 32'd1 || ir[1] !== 1'b0 || bv[1] !== 1'b0)
            $display("FAIL one_frame_done: done=%b cnt=%0d in_ready=%b valid=%b, required 1 1 0 0",
                     dn[1], fc[1], ir[1], bv[1]);
        else n_pass++;
        repeat (5) tick();
        n_checks++;
        if (dn[1] !== 1'b1 || fc[1] !== 32'd1)
            $display("FAIL done_persist: done=%b cnt=%0d, required 1 1", dn[1], fc[1]);
        else n_pass++;
        push_header(NF_TAB[1], SR);
        pulse_start();
        n_checks++;
        if (fc[1] !== 32'd0 || dn[1] !== 1'b0 || by[1] !== 1'b1)
            $display("FAIL restart_clear: cnt=%0d done=%b busy=%b, required 0 0 1", fc[1], dn[1], by[1]);
        else n_pass++;
        drain(200, "hdr_one_again");
        send_frame(24'hFF8000, 24'h12FFFF);
        drain(50, "frame_upper");
        n_checks++;
        if (dn[1] !== 1'b1 || fc[1] !== 32'd1)
            $display("FAIL upper_bits_done: done=%b cnt=%0d, required 1 1", dn[1], fc[1]);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [23:0] l, r;
        sel = 2;
        toggle_mode = 1'b1;
        push_header(NF_TAB[2], SR);
        pulse_start();
        drain(400, "hdr_stall");
        for (int i = 0; i < 3; i++) begin
            l = 24'($urandom);
            r = 24'($urandom);
            send_frame(l, r);
            drain(100, "frame_stall");
            n_checks++;
            if (fc[2] !== 32'(i + 1)) $display("FAIL stall_frame_cnt: cnt=%0d, required %0d", fc[2], i + 1);
            else n_pass++;
        end
        n_checks++;
        if (dn[2] !== 1'b1) $display("FAIL stall_done: done=%b, required 1", dn[2]);
        else n_pass++;
        toggle_mode = 1'b0;
        byte_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_stream();
        logic [15:0] r16;
        int n = 0;
        sel = 2;
        push_header(NF_TAB[2], SR);
        pulse_start();
        drain(200, "hdr_pre_reset");
        in_L = 24'h001234;
        in_R = 24'h00ABCD;
        r16 = in_R[15:0] + 16'h8000;
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h12 ^ 8'h80);
        in_valid = 1'b1;
        while (ir[2] !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        tick();
        in_valid = 1'b0;
        drain(50, "pre_reset_bytes");
        n_checks++;
        if (bv[2] !== 1'b1 || bo[2] !== r16[7:0])
            $display("FAIL byte2_before_reset: byte_out=%h valid=%b, required %h 1", bo[2], bv[2], r16[7:0]);
        else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({bo[2], bv[2], ir[2], by[2], dn[2], fc[2]} !== '0)
            $display("FAIL reset_mid_stream: byte_out=%h valid=%b ready=%b busy=%b done=%b cnt=%0d, required all 0",
                     bo[2], bv[2], ir[2], by[2], dn[2], fc[2]);
        else n_pass++;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        push_header(NF_TAB[2], SR);
        pulse_start();
        n_checks++;
        if (bo[2] !== 8'h52 || bv[2] !== 1'b1)
            $display("FAIL restart_first_byte: byte_out=%h valid=%b, required 52 1", bo[2], bv[2]);
        else n_pass++;
        drain(200, "hdr_post_reset");
    endtask

    task automatic test_zero_frames();
        int n = 0;
        bit ir_seen = 1'b0;
        sel = 3;
        push_header(NF_TAB[3], SR);
        in_L = 24'h000001;
        in_R = 24'h000002;
        in_valid = 1'b1;
        pulse_start();
        while ((exp_q.size() != 0 || n < 60) && n < 200) begin
            if (ir[3] === 1'b1) ir_seen = 1'b1;
            tick();
            n++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (exp_q.size() != 0 || dn[3] !== 1'b1 || ir_seen || fc[3] !== 32'd0)
            $display("FAIL zero_frames: pending=%0d done=%b in_ready_seen=%b cnt=%0d, required 0 1 0 0",
                     exp_q.size(), dn[3], ir_seen, fc[3]);
        else n_pass++;
        exp_q.delete();
        push_header(NF_TAB[3], SR);
        pulse_start();
        n_checks++;
        if (dn[3] !== 1'b0 || by[3] !== 1'b1 || bo[3] !== 8'h52)
            $display("FAIL zero_restart: done=%b busy=%b byte_out=%h, required 0 1 52", dn[3], by[3], bo[3]);
        else n_pass++;
        drain(200, "hdr_zero_again");
        n_checks++;
        if (dn[3] !== 1'b1 || ir[3] !== 1'b0)
            $display("FAIL zero_done_again: done=%b in_ready=%b, required 1 0", dn[3], ir[3]);
        else n_pass++;
    endtask

    initial begin
        foreach (st[i]) st[i] = 1'b0;
        test_reset();
        test_default_header();
        test_single_frame();
        test_stall();
        test_reset_mid_stream();
        test_zero_frames();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
